// File: rtl/sonar_driver.sv
// Ultrasonic range-finder driver: trigger pulse, echo timing, distance in cm.
// Latency: trig/ready change the cycle after measure is sampled; distance updates 3 cycles after echo falls.
// Backpressure: none; measure is only accepted while ready is high and never queued.
module sonar_driver #(
  parameter int unsigned TRIG_CYCLES    = 500,
  parameter int unsigned CM_CYCLES      = 2900,
  parameter int unsigned TIMEOUT_CYCLES = 1_900_000,
  parameter int unsigned HOLDOFF_CYCLES = 500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       measure,
  input  logic       echo,
  output logic       trig,
  output logic       ready,
  output logic [7:0] distance
);

  localparam int unsigned PH_MAX = (TRIG_CYCLES > HOLDOFF_CYCLES) ? TRIG_CYCLES : HOLDOFF_CYCLES;
  localparam int unsigned PH_W   = $clog2(PH_MAX + 1);
  localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned PS_W   = $clog2(CM_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_RISE,
    S_MEASURE,
    S_HOLDOFF
  } state_t;

  state_t          state_q, state_d;
  logic [PH_W-1:0] phase_q, phase_d;   // shared by TRIG and HOLDOFF, never active together
  logic [TO_W-1:0] tmo_q, tmo_d;
  logic [PS_W-1:0] presc_q, presc_d;
  logic [7:0]      cm_q, cm_d;
  logic [7:0]      dist_q, dist_d;
  logic            trig_q, ready_q;
  logic [1:0]      sync_q;
  logic            echo_dly_q;
  logic            echo_s;
  logic            echo_rise, echo_fall;
  logic            cm_tick;

  assign echo_s    = sync_q[1];
  assign echo_rise = echo_s & ~echo_dly_q;
  assign echo_fall = ~echo_s & echo_dly_q;

  // Two-flop synchronizer for the asynchronous echo, plus one delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= 2'b00;
      echo_dly_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], echo};
      echo_dly_q <= echo_s;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      tmo_q   <= '0;
      presc_q <= '0;
      cm_q    <= '0;
      dist_q  <= 8'h00;
      trig_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      tmo_q   <= tmo_d;
      presc_q <= presc_d;
      cm_q    <= cm_d;
      dist_q  <= dist_d;
      trig_q  <= (state_d == S_TRIG);
      ready_q <= (state_d == S_IDLE);
    end
  end

  // Next-state logic; the rising-edge cycle counts as the first echo-high tick.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    tmo_d   = tmo_q;
    presc_d = presc_q;
    cm_d    = cm_q;
    dist_d  = dist_q;
    cm_tick = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (measure) begin
          state_d = S_TRIG;
          phase_d = '0;
          tmo_d   = '0;
          presc_d = '0;
          cm_d    = '0;
        end
      end

      S_TRIG: begin
        if (phase_q == PH_W'(TRIG_CYCLES - 1)) begin
          state_d = S_WAIT_RISE;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end

      S_WAIT_RISE: begin
        tmo_d = tmo_q + TO_W'(1);
        if (tmo_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          dist_d  = 8'hFF;
          state_d = S_HOLDOFF;
          phase_d = '0;
        end else if (echo_rise) begin
          state_d = S_MEASURE;
          cm_tick = 1'b1;
        end
      end

      S_MEASURE: begin
        tmo_d = tmo_q + TO_W'(1);
        // Echo fall takes priority over a coincident timeout.
        if (echo_fall) begin
          dist_d  = cm_q;
          state_d = S_HOLDOFF;
          phase_d = '0;
        end else if (tmo_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          dist_d  = 8'hFF;
          state_d = S_HOLDOFF;
          phase_d = '0;
        end else begin
          cm_tick = 1'b1;
        end
      end

      S_HOLDOFF: begin
        if (phase_q == PH_W'(HOLDOFF_CYCLES - 1)) begin
          state_d = S_IDLE;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Prescaler wrap advances the centimetre count, which saturates at 255 (reported as 8'hFF).
    if (cm_tick) begin
      if (presc_q == PS_W'(CM_CYCLES - 1)) begin
        presc_d = '0;
        cm_d    = (cm_q == 8'hFF) ? 8'hFF : cm_q + 8'd1;
      end else begin
        presc_d = presc_q + PS_W'(1);
      end
    end
  end

  assign trig     = trig_q;
  assign ready    = ready_q;
  assign distance = dist_q;

endmodule

// File: tb/tb_sonar_driver.sv
// Bench for sonar_driver: directed and random echo scenarios against a distance model.
// Echo timing is expressed in cycles after the trigger falls.
// Measure requests are also issued while busy to confirm they are dropped.
module tb_sonar_driver;

  localparam int TRIG = 4;
  localparam int CM   = 10;
  localparam int TMO  = 3000;
  localparam int HOLD = 20;
  localparam int LAT  = 3;   // 2-flop synchronizer + edge register

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       measure = 1'b0;
  logic       echo = 1'b0;
  logic       trig;
  logic       ready;
  logic [7:0] distance;

  int n_checks = 0;
  int n_fail   = 0;

  sonar_driver #(
    .TRIG_CYCLES   (TRIG),
    .CM_CYCLES     (CM),
    .TIMEOUT_CYCLES(TMO),
    .HOLDOFF_CYCLES(HOLD)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .measure (measure),
    .echo    (echo),
    .trig    (trig),
    .ready   (ready),
    .distance(distance)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: distance from pulse width, or 255 when no fall is seen before the timeout.
  function automatic int ref_distance(input int d, input int w);
    if (w == 0) return 255;
    if (d + w + LAT >= TMO) return 255;
    return (w / CM > 255) ? 255 : w / CM;
  endfunction

  // One measurement. Timing index j counts cycles after trig was first seen low.
  // Echo is high for j < pre_len and for d <= j < d+w; measure pulses at j == mj when mj > 0.
  task automatic run_meas(input string tag, input int mlen, input int pre_len,
                          input int d, input int w, input int mj,
                          output int j_upd, output int j_rdy);
    int c;
    int th;
    int ntrig;
    int nchg;
    logic [7:0] d0;
    echo = (pre_len > 0);
    @(negedge clk);
    measure = 1'b1;
    c  = 0;
    th = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      c++;
      if (c >= mlen) measure = 1'b0;
      if (c == 1) begin
        check({tag, "_ready_low"}, ready, 0);
        check({tag, "_trig_high"}, trig, 1);
      end
      if (trig) th++;
      else break;
    end
    measure = 1'b0;
    check({tag, "_trig_width"}, th, TRIG);

    d0    = distance;
    j_upd = -1;
    j_rdy = -1;
    ntrig = 0;
    nchg  = 0;
    for (int j = 0; j < TMO + HOLD + 300; j++) begin
      if (j > 0) @(negedge clk);
      if (distance !== d0) begin
        nchg++;
        d0 = distance;
        if (j_upd < 0) j_upd = j;
      end
      if (trig) ntrig++;
      if (ready) begin
        j_rdy = j;
        break;
      end
      echo    = (j < pre_len) || (j >= d && j < d + w);
      measure = (mj > 0 && j == mj);
    end
    measure = 1'b0;
    echo    = 1'b0;
    check({tag, "_ready_back"}, (j_rdy >= 0), 1);
    check({tag, "_no_retrig"}, ntrig, 0);
    check({tag, "_dist_changes"}, (nchg <= 1), 1);
  endtask

  // Runs a measurement and checks distance plus ready timing against the model.
  task automatic meas_and_check(input string tag, input int mlen, input int pre_len,
                                input int d, input int w, input int mj);
    int ju;
    int jr;
    int exp_d;
    int lo;
    exp_d = ref_distance(d, w);
    run_meas(tag, mlen, pre_len, d, w, mj, ju, jr);
    check({tag, "_distance"}, distance, exp_d);
    if (w > 0 && d + w + LAT < TMO) lo = d + w + LAT - 1 + HOLD;
    else lo = TMO - 1 + HOLD;
    check({tag, "_ready_time"}, (jr >= lo && jr <= lo + 2), 1);
    if (ju >= 0) check({tag, "_holdoff"}, jr - ju, HOLD);
    repeat (4) @(negedge clk);
    check({tag, "_idle_trig"}, trig, 0);
    check({tag, "_idle_ready"}, ready, 1);
  endtask

  initial begin
    int rd;
    int rw;
    int rm;

    // Reset and idle behaviour, including echo activity while idle.
    repeat (3) @(negedge clk);
    #1;
    check("rst_trig", trig, 0);
    check("rst_ready", ready, 1);
    check("rst_dist", distance, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      echo = ~echo;
      @(negedge clk);
      check("idle_echo_trig", trig, 0);
      check("idle_echo_ready", ready, 1);
    end
    echo = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_echo_dist", distance, 0);

    // Directed scenarios.
    meas_and_check("normal", 1, 0, 50, 235, 0);
    meas_and_check("no_echo", 1, 0, 0, 0, 0);
    meas_and_check("pre_high", 1, 5, 20, 100, 0);
    meas_and_check("long_echo", 1, 0, 10, 3000, 0);
    meas_and_check("saturate", 1, 0, 15, 2605, 0);
    meas_and_check("held3_pulse_meas", 3, 0, 30, 157, 100);
    meas_and_check("pulse_holdoff", 1, 0, 40, 88, 40 + 88 + LAT + 8);

    // Random widths, kept off prescaler boundaries and clear of the timeout.
    for (int i = 0; i < 6; i++) begin
      rd = $urandom_range(200, 1);
      rw = CM * $urandom_range(268, 0) + $urandom_range(CM - 2, 1);
      rm = $urandom_range(3, 1);
      meas_and_check("random", rm, 0, rd, rw, 0);
    end

    // Asynchronous reset in the middle of the trigger pulse.
    @(negedge clk);
    measure = 1'b1;
    @(negedge clk);
    measure = 1'b0;
    check("midtrig_trig_on", trig, 1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midtrig_rst_trig", trig, 0);
    check("midtrig_rst_ready", ready, 1);
    check("midtrig_rst_dist", distance, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_trig", trig, 0);
    check("post_rst_ready", ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
